// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the pipe_regfile slice.
//   rf_state_e : sweep FSM states (CLEAR while initialising, READY after)
//   *_DEF      : default geometry (32 x 32-bit, two read ports)
//   init_val() : value the post-reset sweep loads into entry idx
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // Returns the sweep value before sizing. The caller casts it to DATA_W,
  // which zero-extends or truncates as needed.
  function automatic logic [31:0] init_val(input logic [31:0] idx, input int init_idx);
    return (init_idx != 0) ? idx : 32'd0;
  endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// pipe_regfile_if: read/write bus of the register file.
//   rd_addr   : NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   : NUM_RD packed read data,      port k at [k*DATA_W +: DATA_W]
//   we/wr_addr/wr_data : single write port
//   init_busy : high while the init sweep owns the write port
// master = decode-stage client, slave = pipe_regfile.
interface pipe_regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     init_busy;

  modport master (
    output rd_addr, we, wr_addr, wr_data,
    input  rd_data, init_busy
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data,
    output rd_data, init_busy
  );

endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port.
//   mem_i      : whole register array (packed, entry i at [i])
//   rd_addr_i  : read address
//   byp_vld_i  : a user write is committing this cycle and may be forwarded
//   wr_addr_i  : write address, compared for the same-cycle bypass
//   wr_data_i  : write data, returned on a bypass hit
//   rd_data_o  : read data
// Zero forcing is applied last so that it also overrides a bypass hit.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem_i,
  input  logic [ADDR_W-1:0]                rd_addr_i,
  input  logic                             byp_vld_i,
  input  logic [ADDR_W-1:0]                wr_addr_i,
  input  logic [DATA_W-1:0]                wr_data_i,
  output logic [DATA_W-1:0]                rd_data_o
);

  always_comb begin
    rd_data_o = mem_i[rd_addr_i];
    if (byp_vld_i && (rd_addr_i == wr_addr_i)) rd_data_o = wr_data_i;
    if ((ZERO_REG != 0) && (rd_addr_i == '0))  rd_data_o = '0;
  end

endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: parametrised multi-read-port register file for the decode
// stage. After reset a sweep FSM writes every entry with its init value,
// one entry per cycle, while init_busy is high; user writes are dropped
// until the sweep is done.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous, active-high reset; restarts the sweep at entry 0
//   bus : pipe_regfile_if.slave (read ports, write port, init_busy)
// Compile-time option: define REGFILE_BYPASS_EN to forward a committing
// user write to same-cycle readers of that address. Without it, readers see
// the old value until the next cycle.
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int INIT_IDX = 1
) (
  input logic          clk,
  input logic          rst,
  pipe_regfile_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_e                    state_q;
  logic [ADDR_W-1:0]            sweep_idx_q;
  logic                         init_busy_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  // Write-port arbitration. The sweep owns the port in CLEAR and also while
  // rst is held, so entry 0 is rewritten every reset cycle. User writes
  // only land in READY, and address 0 is ignored when it is hard-wired.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_val;
  logic [ADDR_W-1:0] sw_idx;

  always_comb begin
    sw_idx = rst ? '0 : sweep_idx_q;
    wr_en  = 1'b0;
    wr_idx = sw_idx;
    wr_val = DATA_W'(init_val(32'(sw_idx), INIT_IDX));
    if (rst || (state_q == CLEAR)) begin
      wr_en = 1'b1;
    end else if (bus.we && !((ZERO_REG != 0) && (bus.wr_addr == '0))) begin
      wr_en  = 1'b1;
      wr_idx = bus.wr_addr;
      wr_val = bus.wr_data;
    end
  end

  // Sweep FSM; init_busy is registered and drops on the edge that writes
  // the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      sweep_idx_q <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (&sweep_idx_q) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY:   ;
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Array has no reset of its own; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_val;
  end

  // Bypass only qualifies a write that actually commits this edge.
  logic byp_vld;
`ifdef REGFILE_BYPASS_EN
  assign byp_vld = !rst && (state_q == READY) && bus.we;
`else
  assign byp_vld = 1'b0;
`endif

  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .mem_i     (mem_q),
      .rd_addr_i (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .byp_vld_i (byp_vld),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .rd_data_o (rd_data[k])
    );
  end

  assign bus.rd_data   = rd_data;
  assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed bench for pipe_regfile with four read ports,
// 32 x 32-bit, ZERO_REG=1, INIT_IDX=1. Table vectors cover steady-state
// reads/writes; hand sequences cover reset sweeps and dropped writes.
// Expected values follow REGFILE_BYPASS_EN when it is defined.
module tb_pipe_regfile;

  localparam int NRD = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(NRD)) bus ();

  pipe_regfile #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(NRD), .ZERO_REG(1), .INIT_IDX(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed lists are written port 3 first, port 0 last.
  typedef struct {
    string                  name;
    logic [NRD-1:0][4:0]    ra;
    logic                   we;
    logic [4:0]             wa;
    logic [31:0]            wd;
    logic [NRD-1:0][31:0]   exp;
  } vec_t;

  vec_t vecs[11];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NRD-1:0][4:0] ra, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.rd_addr = ra;
    bus.we      = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
  endtask

  task automatic check_ports(input string nm, input logic [NRD-1:0][31:0] exp);
    logic [NRD*32-1:0] rd;
    rd = bus.rd_data;
    for (int k = 0; k < NRD; k++)
      chk($sformatf("%s.p%0d", nm, k), rd[k*32 +: 32], exp[k]);
  endtask

  task automatic read_all(input string nm, input logic [NRD-1:0][4:0] ra,
                          input logic [NRD-1:0][31:0] exp);
    drive(ra, 1'b0, 5'd0, 32'd0);
    #1;
    check_ports(nm, exp);
  endtask

  // Counts edges until init_busy drops; bounded so a stuck FSM still ends.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [NRD-1:0][4:0] ra,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [NRD-1:0][31:0] exp);
    vec_t v;
    v.name = nm; v.ra = ra; v.we = we; v.wa = wa; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("rd_init", {5'd1, 5'd0, 5'd31, 5'd7}, 1'b0, 5'd0, 32'd0,
                  {32'd1, 32'd0, 32'd31, 32'd7});
    vecs[1]  = mk("wr5_same", {5'd6, 5'd6, 5'd5, 5'd5}, 1'b1, 5'd5, 32'hDEADBEEF,
                  BYP ? {32'd6, 32'd6, 32'hDEADBEEF, 32'hDEADBEEF} : {32'd6, 32'd6, 32'd5, 32'd5});
    vecs[2]  = mk("rd5_next", {5'd5, 5'd5, 5'd5, 5'd5}, 1'b0, 5'd0, 32'd0,
                  {4{32'hDEADBEEF}});
    vecs[3]  = mk("wr0_same", {5'd0, 5'd0, 5'd0, 5'd0}, 1'b1, 5'd0, 32'h1234,
                  {4{32'd0}});
    vecs[4]  = mk("rd0_next", {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 5'd0, 32'd0,
                  {4{32'd0}});
    vecs[5]  = mk("wr9_same", {5'd8, 5'd9, 5'd9, 5'd9}, 1'b1, 5'd9, 32'hA5A5A5A5,
                  BYP ? {32'd8, {3{32'hA5A5A5A5}}} : {32'd8, 32'd9, 32'd9, 32'd9});
    vecs[6]  = mk("rd9_next", {5'd9, 5'd9, 5'd9, 5'd9}, 1'b0, 5'd0, 32'd0,
                  {4{32'hA5A5A5A5}});
    vecs[7]  = mk("wr31_same", {5'd3, 5'd2, 5'd30, 5'd31}, 1'b1, 5'd31, 32'd0,
                  BYP ? {32'd3, 32'd2, 32'd30, 32'd0} : {32'd3, 32'd2, 32'd30, 32'd31});
    vecs[8]  = mk("rd31_next", {5'd3, 5'd2, 5'd30, 5'd31}, 1'b0, 5'd0, 32'd0,
                  {32'd3, 32'd2, 32'd30, 32'd0});
    vecs[9]  = mk("wr20_same", {5'd20, 5'd20, 5'd20, 5'd20}, 1'b1, 5'd20, 32'h55,
                  BYP ? {4{32'h55}} : {4{32'd20}});
    vecs[10] = mk("rd20_next", {5'd20, 5'd20, 5'd20, 5'd20}, 1'b0, 5'd0, 32'd0,
                  {4{32'h55}});

    drive('0, 1'b0, 5'd0, 32'd0);

    // Reset held 3 cycles, then the sweep must take exactly 32 cycles.
    rst = 1'b1;
    tick();
    chk("rst_busy", {31'd0, bus.init_busy}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("sweep_len", n, 32'd32);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].wd);
      #1;
      check_ports(vecs[i].name, vecs[i].exp);
      tick();
    end
    drive('0, 1'b0, 5'd0, 32'd0);

    // One-cycle reset mid-operation: full sweep again, user data replaced.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_busy", {31'd0, bus.init_busy}, 32'd1);
    count_busy(n);
    chk("sweep2_len", n, 32'd32);
    read_all("rst2_e20", {5'd20, 5'd20, 5'd20, 5'd20}, {4{32'd20}});
    read_all("rst2_mix", {5'd0, 5'd31, 5'd5, 5'd9}, {32'd0, 32'd31, 32'd5, 32'd9});

    // User writes during the sweep are dropped, including one to an entry
    // the sweep has already passed.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();                                   // sweep writes entry 0
    drive('0, 1'b1, 5'd3, 32'hFF);
    tick();                                   // sweep_idx=1
    drive('0, 1'b1, 5'd1, 32'hFF);
    tick();                                   // sweep_idx=2
    drive('0, 1'b0, 5'd0, 32'd0);
    count_busy(n);
    chk("sweep3_rest", n, 32'd29);
    read_all("drop_sweep", {5'd0, 5'd2, 5'd1, 5'd3}, {32'd0, 32'd2, 32'd1, 32'd3});

    // A write on the CLEAR->READY edge is still dropped.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (31) tick();
    chk("pre_last_busy", {31'd0, bus.init_busy}, 32'd1);
    drive('0, 1'b1, 5'd12, 32'h77);
    tick();
    drive('0, 1'b0, 5'd0, 32'd0);
    chk("last_busy", {31'd0, bus.init_busy}, 32'd0);
    read_all("drop_last", {5'd12, 5'd12, 5'd12, 5'd12}, {4{32'd12}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
